// File: rtl/mem_access_unit_if.sv
// Data-memory request/response port between the M-stage access unit and memory.
// Request side is valid/ready; responses are single-cycle pulses with no backpressure.
interface mem_access_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: issues one dmem request, lane-aligns stores, extends loads.
// Load stalls >=3 cycles, store >=2; holds the request until ready; TIMEOUT bounds REQ+WAIT.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd_M,
  input  logic               mem_wr_M,
  input  logic [2:0]         mem_mask_M,
  input  logic [31:0]        alu_o_M,
  input  logic [31:0]        wr_data_M,
  mem_access_unit_if.master  dmem,
  output logic               stall_mem,
  output logic [31:0]        load_data_M,
  output logic               load_valid,
  output logic               access_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q, to_q;
  logic [2:0]    mask_q;
  logic [1:0]    off_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;

  logic          access, legal, busy, timeout_hit;
  logic [31:0]   st_wdata, ld_ext;
  logic [3:0]    st_wstrb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign access = mem_rd_M | mem_wr_M;
  assign busy   = (state == REQ) || (state == WAIT);

  // Unsigned load widths have no store counterpart.
  always_comb begin
    legal = 1'b0;
    case (mem_mask_M)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~alu_o_M[0];
      3'b010:  legal = (alu_o_M[1:0] == 2'b00);
      3'b100:  legal = ~mem_wr_M;
      3'b101:  legal = ~mem_wr_M & ~alu_o_M[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata = wr_data_M;
    st_wstrb = 4'b1111;
    case (mem_mask_M[1:0])
      2'b00: begin
        st_wdata = {4{wr_data_M[7:0]}};
        st_wstrb = 4'b0001 << alu_o_M[1:0];
      end
      2'b01: begin
        st_wdata = {2{wr_data_M[15:0]}};
        st_wstrb = alu_o_M[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mem_wr_M) st_wstrb = 4'b0000;
  end

  assign ld_byte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    case (mask_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt == CNT_LAST);

  assign stall_mem  = ((state == IDLE) && access && legal) || busy;
  assign access_err = ((state == IDLE) && access && !legal) || timeout_hit;
  assign load_valid = (state == DONE) && !we_q && !to_q;

  assign dmem.dmem_req_valid = (state == REQ);
  assign dmem.dmem_we        = we_q;
  assign dmem.dmem_addr      = addr_q;
  assign dmem.dmem_wdata     = wdata_q;
  assign dmem.dmem_wstrb     = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      to_q        <= 1'b0;
      mask_q      <= 3'b000;
      off_q       <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'b0000;
      load_data_M <= 32'h0;
    end else begin
      cnt <= busy ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (access && legal) begin
          state   <= REQ;
          we_q    <= mem_wr_M;
          to_q    <= 1'b0;
          mask_q  <= mem_mask_M;
          off_q   <= alu_o_M[1:0];
          addr_q  <= {alu_o_M[31:2], 2'b00};
          wdata_q <= st_wdata;
          wstrb_q <= st_wstrb;
        end
        // Timeout wins over a same-cycle handshake so the counter never wraps.
        REQ: if (timeout_hit) begin
          state <= DONE;
          to_q  <= 1'b1;
        end else if (dmem.dmem_req_ready) begin
          state <= we_q ? DONE : WAIT;
        end
        WAIT: if (timeout_hit) begin
          state <= DONE;
          to_q  <= 1'b1;
        end else if (dmem.dmem_rsp_valid) begin
          state       <= DONE;
          load_data_M <= ld_ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors against a scoreboard of
// expected requests and load results, plus timeout and reset-in-WAIT sequences.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_M, mem_wr_M;
  logic [2:0]  mem_mask_M;
  logic [31:0] alu_o_M, wr_data_M;
  logic        stall_mem, load_valid, access_err;
  logic [31:0] load_data_M;

  always #5 clk = ~clk;

  mem_access_unit_if dif();

  mem_access_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M), .mem_mask_M(mem_mask_M),
    .alu_o_M(alu_o_M), .wr_data_M(wr_data_M),
    .dmem(dif),
    .stall_mem(stall_mem), .load_data_M(load_data_M),
    .load_valid(load_valid), .access_err(access_err)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  mask;
    logic [31:0] addr, wdata, rdata;
    int          rdy_dly;
    logic        no_rsp;
    logic [31:0] exp_ld, exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_stall, exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
  } req_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_q[$];
  req_t        req_q[$];
  logic [31:0] ld_exp;
  logic [31:0] last_load = 32'h0;
  vec_t        tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] mask,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dly, input logic no_rsp,
                              input logic [31:0] exp_ld, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_wstrb, input int exp_stall, input int exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mask = mask; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rdy_dly = dly; v.no_rsp = no_rsp; v.exp_ld = exp_ld; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.exp_stall = exp_stall; v.exp_err = exp_err;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && load_valid) begin
      if (ld_q.size() == 0) chk("load_valid spurious", 32'(load_valid), 32'h0);
      else begin
        ld_exp = ld_q.pop_front();
        chk("load_data_M", load_data_M, ld_exp);
      end
    end
  end

  task automatic run_vec(input vec_t v, input string nm);
    int   stall_cyc = 0, err_cnt = 0, waited = 0;
    bit   rsp_pend = 0, done = 0;
    req_t r;
    mem_rd_M = v.rd; mem_wr_M = v.wr; mem_mask_M = v.mask;
    alu_o_M = v.addr; wr_data_M = v.wdata;
    if (v.exp_stall > 0) begin
      r.we = v.wr; r.addr = {v.addr[31:2], 2'b00};
      r.wdata = v.exp_wdata; r.wstrb = v.wr ? v.exp_wstrb : 4'b0000;
      req_q.push_back(r);
      if (!v.wr && !v.no_rsp) ld_q.push_back(v.exp_ld);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_mem) stall_cyc++;
      if (access_err) err_cnt++;
      dif.dmem_rsp_valid = rsp_pend;
      dif.dmem_rdata     = rsp_pend ? v.rdata : 32'h0;
      rsp_pend           = 0;
      dif.dmem_req_ready = 1'b0;
      if (dif.dmem_req_valid) begin
        if (req_q.size() == 0) chk({nm, " req spurious"}, 32'(dif.dmem_req_valid), 32'h0);
        else begin
          chk({nm, " addr"}, dif.dmem_addr, req_q[0].addr);
          chk({nm, " we"}, 32'(dif.dmem_we), 32'(req_q[0].we));
          chk({nm, " wstrb"}, 32'(dif.dmem_wstrb), 32'(req_q[0].wstrb));
          if (req_q[0].we) chk({nm, " wdata"}, dif.dmem_wdata, req_q[0].wdata);
          if (waited >= v.rdy_dly) begin
            dif.dmem_req_ready = 1'b1;
            void'(req_q.pop_front());
            rsp_pend = !v.wr && !v.no_rsp;
          end
          waited++;
        end
      end
      if (!stall_mem && (stall_cyc > 0 || access_err)) done = 1;
    end
    if (!done) chk({nm, " completion bound"}, 32'(done), 32'h1);
    chk({nm, " stall cycles"}, 32'(stall_cyc), 32'(v.exp_stall));
    chk({nm, " access_err pulses"}, 32'(err_cnt), 32'(v.exp_err));
    @(posedge clk); #1;
    mem_rd_M = 0; mem_wr_M = 0; mem_mask_M = 3'b000; alu_o_M = 0; wr_data_M = 0;
    dif.dmem_req_ready = 0; dif.dmem_rsp_valid = 0; dif.dmem_rdata = 0;
    chk({nm, " requests outstanding"}, 32'(req_q.size()), 32'h0);
    chk({nm, " loads outstanding"}, 32'(ld_q.size()), 32'h0);
    if (!v.wr && !v.no_rsp && v.exp_stall > 0) last_load = v.exp_ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 3, 0);
    tbl[1]  = mk(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 0, 3, 0);
    tbl[2]  = mk(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0, 0, 32'h00000080, 0, 0, 3, 0);
    tbl[3]  = mk(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 0, 0, 32'h000080FF, 0, 0, 3, 0);
    tbl[4]  = mk(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 0, 0, 32'hFFFF80FF, 0, 0, 3, 0);
    tbl[5]  = mk(1, 0, 3'b000, 32'h100, 0, 32'h80FF1234, 0, 0, 32'h00000034, 0, 0, 3, 0);
    tbl[6]  = mk(1, 0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 2, 0, 32'h0BADF00D, 0, 0, 5, 0);
    tbl[7]  = mk(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 4, 0, 0, 32'hABABABAB, 4'b0010, 6, 0);
    tbl[8]  = mk(0, 1, 3'b001, 32'h202, 32'h1234CDEF, 0, 0, 0, 0, 32'hCDEFCDEF, 4'b1100, 2, 0);
    tbl[9]  = mk(0, 1, 3'b001, 32'h200, 32'h00005A5A, 0, 0, 0, 0, 32'h5A5A5A5A, 4'b0011, 2, 0);
    tbl[10] = mk(0, 1, 3'b010, 32'h204, 32'h11223344, 0, 0, 0, 0, 32'h11223344, 4'b1111, 2, 0);
    tbl[11] = mk(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0, 32'hCAFEF00D, 4'b1111, 2, 0);
    tbl[12] = mk(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 3'b001, 32'h003, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mk(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[16] = mk(1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst = 1; mem_rd_M = 0; mem_wr_M = 0; mem_mask_M = 0; alu_o_M = 0; wr_data_M = 0;
    dif.dmem_req_ready = 0; dif.dmem_rsp_valid = 0; dif.dmem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset stall_mem", 32'(stall_mem), 32'h0);
    chk("reset req_valid", 32'(dif.dmem_req_valid), 32'h0);
    chk("reset load_data_M", load_data_M, 32'h0);
    chk("reset load_valid", 32'(load_valid), 32'h0);
    chk("reset access_err", 32'(access_err), 32'h0);
    chk("reset wstrb", 32'(dif.dmem_wstrb), 32'h0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Load accepted, memory never answers: timeout after 8 REQ+WAIT cycles.
    run_vec(mk(1, 0, 3'b010, 32'h400, 0, 0, 0, 1, 0, 0, 0, 9, 1), "timeout");
    chk("timeout keeps load_data_M", load_data_M, last_load);
    dif.dmem_rsp_valid = 1; dif.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray rsp load_valid", 32'(load_valid), 32'h0);
    chk("stray rsp stall_mem", 32'(stall_mem), 32'h0);
    @(posedge clk); #1;
    dif.dmem_rsp_valid = 0; dif.dmem_rdata = 0;
    @(negedge clk);
    chk("stray rsp load_data_M", load_data_M, last_load);
    @(posedge clk); #1;

    // Reset while a load waits for its response.
    mem_rd_M = 1; mem_mask_M = 3'b010; alu_o_M = 32'h500;
    @(negedge clk);
    @(negedge clk);
    chk("rst seq req_valid in REQ", 32'(dif.dmem_req_valid), 32'h1);
    dif.dmem_req_ready = 1;
    @(negedge clk);
    dif.dmem_req_ready = 0;
    chk("rst seq stall in WAIT", 32'(stall_mem), 32'h1);
    chk("rst seq req_valid in WAIT", 32'(dif.dmem_req_valid), 32'h0);
    rst = 1; mem_rd_M = 0; mem_mask_M = 0; alu_o_M = 0;
    @(negedge clk);
    chk("rst seq stall_mem", 32'(stall_mem), 32'h0);
    chk("rst seq req_valid", 32'(dif.dmem_req_valid), 32'h0);
    chk("rst seq load_data_M", load_data_M, 32'h0);
    chk("rst seq load_valid", 32'(load_valid), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(negedge clk);
    chk("final loads outstanding", 32'(ld_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
